axis_stream_fifo: RTL and testbench
===================================

Name: axis_stream_fifo

Overview:
- Single-clock AXI-Stream FIFO that buffers sample words from the capture engine and delivers them to the DMA master.
- Full valid/ready handshake on both sides.
- Generates master_tlast on every packet_len-th output beat, so the DMA sees bounded packets.
- Exposes fill level and full/empty status for software and overrun detection.

Parameters:
- dataw, 32, width of tdata on both sides.
- depth, 512, number of storage words; power of two, minimum 2.

Ports:
- clk  in  1  single clock for both stream sides.
- reset_n  in  1  asynchronous, active-low reset.
- slave_tdata  in  dataw  input sample word.
- slave_tvalid  in  1  input word valid.
- slave_tready  out  1  FIFO can accept a word.
- master_tdata  out  dataw  output word (head of FIFO).
- master_tvalid  out  1  output word valid.
- master_tlast  out  1  output word is last of packet.
- master_tready  in  1  downstream accepts word.
- packet_len  in  clog2(depth)+1  beats per packet; 0 disables tlast.
- level  out  clog2(depth)+1  number of words stored, 0..depth.
- full  out  1  level == depth.
- empty  out  1  level == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset state (while reset_n low): read/write pointers, level and beat counter cleared; slave_tready=0 during reset, 1 from first clk after release; master_tvalid=0, master_tlast=0, level=0, full=0, empty=1. Storage contents undefined.
- Write: on rising clk when slave_tvalid && slave_tready, store slave_tdata at wptr; wptr increments modulo depth.
- slave_tready = !full (registered or combinational, but never 1 when full).
- Read (first-word fall-through): master_tdata shows the word at rptr whenever master_tvalid=1; master_tvalid = !empty.
- Pop on rising clk when master_tvalid && master_tready; rptr increments modulo depth.
- Latency: a word written into an empty FIFO at edge N appears with master_tvalid=1 after edge N (valid for the N+1 cycle).
- Output stability: master_tdata and master_tvalid hold stable while master_tvalid=1 and master_tready=0.
- Level: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Full: a simultaneous read does not enable a write; slave_tready stays 0 that cycle and rises the following cycle.
- Empty: with level==0 and a write in the same cycle, no read occurs (master_tvalid=0 that cycle).
- Pointer wrap: pointers are clog2(depth) bits and wrap naturally; full/empty are derived from level, not pointer equality.
- tlast beat counter: counts accepted output beats.
  - When packet_len != 0, master_tlast = master_tvalid && (beatcnt == packet_len-1).
  - On the handshake of that beat, beatcnt resets to 0; otherwise it increments.
  - packet_len == 0 forces master_tlast=0 and holds beatcnt at 0.
  - packet_len is expected static during operation; if changed, the comparison uses the new value immediately, with no extra state.
- Reset mid-operation: asynchronously discards all data; outputs return to reset values immediately.
- No overflow/underflow possible; writes when full and reads when empty are ignored by the handshake.

Test Plan:
- Reset then single word: reset_n low 5 cycles, release, write 0xDEADBEEF with master_tready=0 -> level=1, empty=0, master_tvalid=1, master_tdata=0xDEADBEEF; raise master_tready for one cycle -> level=0, empty=1, master_tvalid=0.
- Fill to full: depth=512, master_tready=0, write 0..511 -> full=1, slave_tready=0, level=512; word 512 offered is not accepted; drain -> data 0..511 in order, no loss or duplication.
- Streaming with master_tready=1 (as DMA does): continuous writes of incrementing data for 1000 words -> output sequence identical, level never exceeds 1, pointer wrap seamless.
- Simultaneous read/write at full: full FIFO, master_tready=1, slave_tvalid=1 -> first cycle only a read (level=511), next cycle write accepted, level stays 511 thereafter.
- tlast: packet_len=128, stream 300 words -> master_tlast high on output beats 127 and 255 only; packet_len=0 -> master_tlast never asserted.
- Async reset mid-stream: assert reset_n low between clock edges with level=40 -> master_tvalid=0, level=0, empty=1 immediately; after release, new data flows correctly starting at beat count 0.

Source files
------------

// File: rtl/axis_stream_fifo.sv
// rtl/axis_stream_fifo.sv - single-clock AXI-Stream FIFO with packet tlast generation and fill status
//
// Buffers sample words from the capture engine and hands them to the DMA master
// with first-word fall-through on the output side.
//
// Ports:
//   clk            single clock for both stream sides
//   reset_n        asynchronous active-low reset
//   slave_tdata    input sample word
//   slave_tvalid   input word valid
//   slave_tready   FIFO can accept a word (never high while full)
//   master_tdata   word at the head of the FIFO
//   master_tvalid  head word valid (FIFO not empty)
//   master_tlast   head word closes a packet of packet_len beats
//   master_tready  downstream accepts the head word
//   packet_len     beats per packet; 0 disables tlast
//   level          number of stored words, 0..depth
//   full           level == depth
//   empty          level == 0

module axis_stream_fifo #(
    parameter int dataw = 32,
    parameter int depth = 512
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [dataw-1:0]           slave_tdata,
    input  logic                       slave_tvalid,
    output logic                       slave_tready,
    output logic [dataw-1:0]           master_tdata,
    output logic                       master_tvalid,
    output logic                       master_tlast,
    input  logic                       master_tready,
    input  logic [$clog2(depth):0]     packet_len,
    output logic [$clog2(depth):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;

    logic [dataw-1:0] mem [depth];

    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;
    logic [lw-1:0] level_q;
    logic [lw-1:0] beatcnt;
    // Holds slave_tready low until the first clock edge after reset release.
    logic          running;

    logic do_write;
    logic do_read;
    logic last_beat;

    // Full/empty come from the level counter, so pointer equality never
    // has to be disambiguated.
    assign level         = level_q;
    assign full          = (level_q == lw'(depth));
    assign empty         = (level_q == '0);

    // full is registered state, so a pop in the same cycle cannot open the
    // input; the write slot appears on the following cycle.
    assign slave_tready  = running && !full;
    assign master_tvalid = !empty;
    assign master_tdata  = mem[rptr];

    assign do_write = slave_tvalid && slave_tready;
    assign do_read  = master_tvalid && master_tready;

    // packet_len is compared live; a zero length suppresses tlast entirely.
    assign last_beat    = (packet_len != '0) && (beatcnt == (packet_len - lw'(1)));
    assign master_tlast = master_tvalid && last_beat;

    // Storage has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr] <= slave_tdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            running <= 1'b1;
            if (do_write) begin
                wptr <= wptr + aw'(1);
            end
            if (do_read) begin
                rptr <= rptr + aw'(1);
            end
            case ({do_write, do_read})
                2'b10:   level_q <= level_q + lw'(1);
                2'b01:   level_q <= level_q - lw'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beatcnt <= '0;
        end else if (packet_len == '0) begin
            beatcnt <= '0;
        end else if (do_read) begin
            if (last_beat) begin
                beatcnt <= '0;
            end else begin
                beatcnt <= beatcnt + lw'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb/tb_axis_stream_fifo.sv - scoreboard testbench for axis_stream_fifo
module tb_axis_stream_fifo;

    localparam int dataw = 32;
    localparam int depth = 512;
    localparam int lw    = $clog2(depth) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [dataw-1:0] slave_tdata = '0;
    logic             slave_tvalid = 1'b0;
    logic             slave_tready;
    logic [dataw-1:0] master_tdata;
    logic             master_tvalid;
    logic             master_tlast;
    logic             master_tready = 1'b0;
    logic [lw-1:0]    packet_len = '0;
    logic [lw-1:0]    level;
    logic             full;
    logic             empty;

    axis_stream_fifo #(.dataw(dataw), .depth(depth)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .slave_tdata(slave_tdata),
        .slave_tvalid(slave_tvalid),
        .slave_tready(slave_tready),
        .master_tdata(master_tdata),
        .master_tvalid(master_tvalid),
        .master_tlast(master_tlast),
        .master_tready(master_tready),
        .packet_len(packet_len),
        .level(level),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [dataw-1:0] data;
        logic             last;
    } exp_t;

    exp_t sb[$];
    int   tlast_pos[$];
    int   checks = 0;
    int   failures = 0;
    int   plen = 0;
    int   push_idx = 0;
    int   out_idx = 0;
    int   tlast_cnt = 0;
    int   max_level = 0;
    bit   track = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (track && int'(level) > max_level) max_level = int'(level);
            if (master_tvalid && master_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("beat_data", 64'(master_tdata), 64'(e.data));
                    check("beat_tlast", 64'(master_tlast), 64'(e.last));
                end
                if (master_tlast) begin
                    tlast_cnt++;
                    tlast_pos.push_back(out_idx);
                end
                out_idx++;
            end
        end
    end

    task automatic clear_model();
        sb.delete();
        tlast_pos.delete();
        push_idx  = 0;
        out_idx   = 0;
        tlast_cnt = 0;
        max_level = 0;
    endtask

    task automatic do_reset(input int len);
        slave_tvalid  = 1'b0;
        master_tready = 1'b0;
        packet_len    = lw'(len);
        plen          = len;
        reset_n       = 1'b0;
        clear_model();
        repeat (5) @(posedge clk);
        #1;
        check("rst_slave_tready", 64'(slave_tready), 64'd0);
        check("rst_master_tvalid", 64'(master_tvalid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_tready_before_edge", 64'(slave_tready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_tready_after_edge", 64'(slave_tready), 64'd1);
    endtask

    // Offers one word and waits (bounded) for acceptance; leaves tvalid high.
    task automatic write_word(input logic [dataw-1:0] d);
        int n;
        exp_t e;
        slave_tdata  = d;
        slave_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (slave_tready) begin
                e.data = d;
                e.last = (plen != 0) && ((push_idx % plen) == plen - 1);
                sb.push_back(e);
                push_idx++;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                check("write_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        master_tready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (empty) break;
            n++;
            if (n > 2000) begin
                check("drain_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        master_tready = 1'b0;
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // Reset, then a single word.
        do_reset(0);
        write_word(32'hDEADBEEF);
        slave_tvalid = 1'b0;
        check("t1_level", 64'(level), 64'd1);
        check("t1_empty", 64'(empty), 64'd0);
        check("t1_tvalid", 64'(master_tvalid), 64'd1);
        check("t1_tdata", 64'(master_tdata), 64'hDEADBEEF);
        master_tready = 1'b1;
        @(posedge clk);
        #1;
        master_tready = 1'b0;
        check("t1_level_after", 64'(level), 64'd0);
        check("t1_empty_after", 64'(empty), 64'd1);
        check("t1_tvalid_after", 64'(master_tvalid), 64'd0);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Fill to full, refuse one more, drain in order.
        do_reset(0);
        for (int i = 0; i < depth; i++) write_word(32'(i));
        slave_tdata = 32'd512;
        check("t2_full", 64'(full), 64'd1);
        check("t2_level", 64'(level), 64'd512);
        @(negedge clk);
        check("t2_tready", 64'(slave_tready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        slave_tvalid = 1'b0;
        check("t2_level_hold", 64'(level), 64'd512);
        check("t2_head", 64'(master_tdata), 64'd0);
        drain();
        check("t2_out_count", 64'(out_idx), 64'd512);

        // Streaming with the sink always ready, tlast disabled.
        do_reset(0);
        master_tready = 1'b1;
        track = 1;
        for (int i = 0; i < 1000; i++) write_word(32'h1000_0000 + 32'(i));
        slave_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        track = 0;
        check("t3_max_level_le1", 64'(max_level <= 1), 64'd1);
        check("t3_out_count", 64'(out_idx), 64'd1000);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);
        check("t3_no_tlast", 64'(tlast_cnt), 64'd0);

        // Simultaneous read and write offered at full.
        do_reset(0);
        for (int i = 0; i < depth; i++) write_word(32'h2000_0000 + 32'(i));
        master_tready = 1'b1;
        slave_tdata   = 32'h3000_0000;
        @(negedge clk);
        check("t4_tready_at_full", 64'(slave_tready), 64'd0);
        @(posedge clk);
        #1;
        check("t4_level_read_only", 64'(level), 64'd511);
        for (int i = 0; i < 10; i++) begin
            write_word(32'h3000_0000 + 32'(i));
            check("t4_level_steady", 64'(level), 64'd511);
        end
        slave_tvalid = 1'b0;
        drain();
        check("t4_out_count", 64'(out_idx), 64'd522);

        // tlast every 128 beats over 300 beats.
        do_reset(128);
        master_tready = 1'b1;
        for (int i = 0; i < 300; i++) write_word(32'h4000_0000 + 32'(i));
        slave_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_tlast_count", 64'(tlast_cnt), 64'd2);
        check("t5_tlast_pos0", 64'(tlast_pos.size() > 0 ? tlast_pos[0] : -1), 64'd127);
        check("t5_tlast_pos1", 64'(tlast_pos.size() > 1 ? tlast_pos[1] : -1), 64'd255);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset mid-stream with level 40 and beat count advanced.
        do_reset(16);
        master_tready = 1'b1;
        for (int i = 0; i < 5; i++) write_word(32'h5000_0000 + 32'(i));
        slave_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        master_tready = 1'b0;
        for (int i = 0; i < 40; i++) write_word(32'h6000_0000 + 32'(i));
        slave_tvalid = 1'b0;
        check("t6_level40", 64'(level), 64'd40);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        check("t6_async_tvalid", 64'(master_tvalid), 64'd0);
        check("t6_async_level", 64'(level), 64'd0);
        check("t6_async_empty", 64'(empty), 64'd1);
        check("t6_async_tready", 64'(slave_tready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        master_tready = 1'b1;
        for (int i = 0; i < 20; i++) write_word(32'h7000_0000 + 32'(i));
        slave_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_tlast_count", 64'(tlast_cnt), 64'd1);
        check("t6_tlast_pos", 64'(tlast_pos.size() > 0 ? tlast_pos[0] : -1), 64'd15);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
